// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in, parallel-out receiver for the PISO link.
// Shifts one bit per qualified clock into sr, counts bits in cnt, and hands
// each completed WIDTH-bit word to a registered valid/ready output port.
// Reports dropped words (sticky overflow) and mid-word start-of-frame
// (one-cycle sof_err pulse).
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sin,
  input  logic             sin_vld,
  input  logic             sin_sof,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             sof_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;

  logic [CW-1:0]    base_cnt;
  logic [CW-1:0]    next_cnt;
  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             accept;
  logic             drop;

  // Next-state terms: sof restarts the count, the bit shifts in, and the word
  // completes when this bit is the last one of the word.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    base_cnt = cnt;
    shifted  = sr;
    if (sin_sof) begin
      base_cnt = '0;
    end
    if (MSB_FIRST) begin
      shifted = {sr[WIDTH-2:0], sin};
    end else begin
      shifted = {sin, sr[WIDTH-1:1]};
    end
    complete = sin_vld && (base_cnt == LAST);
    next_cnt = complete ? '0 : base_cnt + 1'b1;
    accept   = out_vld && out_rdy;
    drop     = complete && out_vld && !out_rdy;
  end

  // Shift register, bit counter, output port and status flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sr       <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_vld  <= 1'b0;
      overflow <= 1'b0;
      sof_err  <= 1'b0;
    end else begin
      // Partial word abandoned by a new start-of-frame.
      sof_err <= sin_vld && sin_sof && (cnt != '0);

      if (sin_vld) begin
        sr  <= shifted;
        cnt <= next_cnt;
      end

      // A completing word loads when the port is empty or being drained this
      // edge, which gives back-to-back words with no bubble.
      if (complete && (!out_vld || out_rdy)) begin
        out_data <= shifted;
        out_vld  <= 1'b1;
      end else if (accept) begin
        out_vld <= 1'b0;
      end

      // Set has priority over clear so a coincident drop is never lost.
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: an LSB-first and an MSB-first instance share
// all inputs and are compared every cycle against a queue-based word model,
// plus directed constant checks for the documented scenarios.
module tb_sipo_deserializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         sin = 1'b0;
  logic         sin_vld = 1'b0;
  logic         sin_sof = 1'b0;
  logic         out_rdy = 1'b0;
  logic         ovf_clr = 1'b0;

  logic [W-1:0] data_l, data_m;
  logic         vld_l, vld_m, ovf_l, ovf_m, sofe_l, sofe_m;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  bit           q[$];
  logic         m_vld = 1'b0;
  logic [W-1:0] m_data_l = '0;
  logic [W-1:0] m_data_m = '0;
  logic         m_ovf = 1'b0;
  logic         m_sof = 1'b0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rstn(rstn), .sin(sin), .sin_vld(sin_vld), .sin_sof(sin_sof),
    .out_data(data_l), .out_vld(vld_l), .out_rdy(out_rdy),
    .overflow(ovf_l), .ovf_clr(ovf_clr), .sof_err(sofe_l)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rstn(rstn), .sin(sin), .sin_vld(sin_vld), .sin_sof(sin_sof),
    .out_data(data_m), .out_vld(vld_m), .out_rdy(out_rdy),
    .overflow(ovf_m), .ovf_clr(ovf_clr), .sof_err(sofe_m)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: bits of the current word collect in a queue; a full queue is a word.
  task automatic model(input logic b, input logic v, input logic s,
                       input logic r, input logic c, input logic rs);
    bit           complete;
    bit           dropped;
    logic [W-1:0] wl, wm;
    complete = 0;
    dropped  = 0;
    wl = '0;
    wm = '0;
    if (!rs) begin
      q.delete();
      m_vld = 0; m_data_l = '0; m_data_m = '0; m_ovf = 0; m_sof = 0;
      return;
    end
    m_sof = 0;
    if (v) begin
      if (s && q.size() != 0) begin
        m_sof = 1;
        q.delete();
      end
      q.push_back(b);
      if (q.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wl[i]       = q[i];
          wm[W-1-i]   = q[i];
        end
        complete = 1;
        q.delete();
      end
    end
    if (complete && (!m_vld || r)) begin
      m_data_l = wl;
      m_data_m = wm;
      m_vld    = 1;
    end else if (complete) begin
      dropped = 1;
    end else if (m_vld && r) begin
      m_vld = 0;
    end
    if (dropped) m_ovf = 1;
    else if (c) m_ovf = 0;
  endtask

  task automatic step(input logic b, input logic v, input logic s,
                      input logic r, input logic c, input logic rs);
    sin = b; sin_vld = v; sin_sof = s; out_rdy = r; ovf_clr = c; rstn = rs;
    model(b, v, s, r, c, rs);
    @(posedge clk);
    #1;
    check("vld_l", vld_l, m_vld);
    check("vld_m", vld_m, m_vld);
    check("data_l", data_l, m_data_l);
    check("data_m", data_m, m_data_m);
    check("ovf_l", ovf_l, m_ovf);
    check("ovf_m", ovf_m, m_ovf);
    check("sofe_l", sofe_l, m_sof);
    check("sofe_m", sofe_m, m_sof);
  endtask

  // Sends w[0] first; sof on the first bit, ovf_clr on the last bit.
  task automatic send_word(input logic [W-1:0] w, input logic sof,
                           input logic rdy, input logic clr_last);
    for (int i = 0; i < W; i++)
      step(w[i], 1'b1, sof && (i == 0), rdy, clr_last && (i == W - 1), 1'b1);
  endtask

  initial begin
    // Reset
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("rst_vld", vld_l, 1'b0);
    check("rst_data", data_l, 4'b0000);
    check("rst_ovf", ovf_l, 1'b0);

    // Bits 1,0,0,1 with sof and out_rdy=1
    send_word(4'b1001, 1'b1, 1'b1, 1'b0);
    check("w1_data_l", data_l, 4'b1001);
    check("w1_data_m", data_m, 4'b1001);
    check("w1_vld", vld_l, 1'b1);
    step(0, 0, 0, 1, 0, 1);
    check("w1_vld_pulse", vld_l, 1'b0);

    // Bits 1,1,0,0
    send_word(4'b0011, 1'b0, 1'b1, 1'b0);
    check("w2_data_m", data_m, 4'b1100);
    check("w2_data_l", data_l, 4'b0011);
    step(0, 0, 0, 1, 0, 1);

    // 0110 with 0-3 cycle gaps between bits
    for (int i = 0; i < W; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step($urandom % 2, 0, $urandom % 2, 1, 0, 1);
      step(((4'b0110 >> i) & 1) != 0, 1, 0, 1, 0, 1);
      if (i < W - 1) check("gap_no_vld", vld_l, 1'b0);
    end
    check("gap_data", data_l, 4'b0110);
    check("gap_vld", vld_l, 1'b1);
    step(0, 0, 0, 1, 0, 1);

    // Backpressure: 1010 held, 0101 dropped
    send_word(4'b1010, 1'b0, 1'b0, 1'b0);
    check("bp_first", data_l, 4'b1010);
    send_word(4'b0101, 1'b0, 1'b0, 1'b0);
    check("bp_ovf", ovf_l, 1'b1);
    check("bp_hold", data_l, 4'b1010);
    step(0, 0, 0, 1, 0, 1);
    check("bp_consumed", vld_l, 1'b0);
    step(0, 0, 0, 1, 1, 1);
    check("bp_clr", ovf_l, 1'b0);
    send_word(4'b1111, 1'b0, 1'b0, 1'b0);
    send_word(4'b0001, 1'b0, 1'b0, 1'b1);
    check("bp_set_wins", ovf_l, 1'b1);
    check("bp_hold2", data_l, 4'b1111);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 1, 0, 1);

    // Two bits, then sof restarting word 0011 (sent 1,1,0,0)
    step(1, 1, 0, 1, 0, 1);
    step(0, 1, 0, 1, 0, 1);
    step(1, 1, 1, 1, 0, 1);
    check("sof_pulse", sofe_l, 1'b1);
    step(1, 1, 0, 1, 0, 1);
    check("sof_once", sofe_l, 1'b0);
    step(0, 1, 0, 1, 0, 1);
    step(0, 1, 0, 1, 0, 1);
    check("sof_word", data_l, 4'b0011);
    check("sof_vld", vld_l, 1'b1);
    step(0, 0, 0, 1, 0, 1);

    // Reset mid-word with a held word
    send_word(4'b1110, 1'b0, 1'b0, 1'b0);
    step(1, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check("mid_rst_vld", vld_l, 1'b0);
    check("mid_rst_data", data_l, 4'b0000);
    send_word(4'b1011, 1'b0, 1'b1, 1'b0);
    check("post_rst_word", data_l, 4'b1011);
    check("post_rst_word_m", data_m, 4'b1101);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++)
      step($urandom % 2, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom % 2, $urandom_range(0, 5) == 0, $urandom_range(0, 99) != 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
